apu_frame_sequencer: RTL and testbench
======================================

Name: apu_frame_sequencer

Overview:
- Frame counter for the APU, modelled on register $4017.
- Generates the quarter-frame strobe that clocks the noise and pulse envelopes, and the half-frame strobe that clocks the length counters.
- Raises the frame IRQ and schedules all of these from a single APU-cycle enable.
- Sits between the CPU register-write path and the per-channel envelope/length logic, e.g. the noise channel's counter load/decrement.

Parameters:
- STEP1, 3728, APU tick count at which step 1 fires
- STEP2, 7456, APU tick count at which step 2 fires
- STEP3, 11185, APU tick count at which step 3 fires
- STEP4, 14914, APU tick count at which step 4 fires
- STEP5, 18640, APU tick count at which step 5 fires (5-step mode only)
- CNT_W, 15, width of the tick counter; must hold STEP5

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  APU-cycle enable, one clk wide; the sequencer advances only on tick
- wr_en  in  1  one-clk write strobe for $4017
- wr_data  in  8  write data; [7] = mode (0 = 4-step, 1 = 5-step), [6] = irq_inhibit, [5:0] ignored
- irq_ack  in  1  one-clk strobe from a $4015 read; clears the frame IRQ flag
- quarter_frame  out  1  one-clk pulse that clocks envelopes
- half_frame  out  1  one-clk pulse that clocks length counters
- irq  out  1  frame IRQ flag, level
- mode  out  1  current mode bit
- step  out  3  index of the last step fired (0 after reset or wrap)

Behaviour:
- Reset (async, rst=1): cnt=0, mode=0, inhibit=0, irq=0, pending=0, quarter_frame=0, half_frame=0, step=0.
- All outputs are registered. quarter_frame and half_frame are 0 in every cycle in which they are not explicitly pulsed.

Write (wr_en=1), evaluated at posedge, highest priority:
- mode <= wr_data[7]; inhibit <= wr_data[6].
- If wr_data[6]=1, irq <= 0.
- pending <= 1.
- If wr_data[7]=1, quarter_frame and half_frame both pulse high in the next clk cycle (latency 1 clk, independent of tick).
- A tick in the same cycle as wr_en is discarded: no count, no events.

Tick with pending=1:
- cnt <= 0; pending <= 0; step <= 0; no events.

Tick with pending=0, compare the current cnt value:
- 4-step mode:
  - cnt==STEP1: quarter_frame; step <= 1.
  - cnt==STEP2: quarter_frame and half_frame; step <= 2.
  - cnt==STEP3: quarter_frame; step <= 3.
  - cnt==STEP4: quarter_frame and half_frame; irq <= 1 if inhibit=0; cnt <= 0; step <= 0 (wrap).
  - Otherwise: cnt <= cnt+1.
- 5-step mode:
  - cnt==STEP1: quarter_frame; step <= 1.
  - cnt==STEP2: quarter_frame and half_frame; step <= 2.
  - cnt==STEP3: quarter_frame; step <= 3.
  - cnt==STEP4: no event; step <= 4.
  - cnt==STEP5: quarter_frame and half_frame; cnt <= 0; step <= 0 (wrap).
  - Never sets irq.
- For non-wrapping steps, cnt <= cnt+1 as well.
- Event pulses appear in the clk cycle after the tick edge (registered, 1 clk latency).

IRQ:
- Once set, irq holds until irq_ack, a write with wr_data[6]=1, or rst.
- irq_ack in the same cycle as an irq set event: set wins, irq stays 1.
- Inhibit write in the same cycle as a step-4 tick: the write wins, the tick is discarded, irq stays 0.

Mode change mid-frame:
- Only mode and inhibit are updated at the write; thresholds apply from the next counted tick, after the pending reset.

Arithmetic and limits:
- cnt is unsigned CNT_W bits. cnt never exceeds STEP5, or STEP4 in 4-step mode, so no natural wrap-around.
- Parameters must satisfy 0 < STEP1 < STEP2 < STEP3 < STEP4 < STEP5 < 2^CNT_W.

Reset mid-operation:
- rst asserted at any time immediately forces reset values.
- Any in-flight pulse or pending reset is lost.

Test Plan:
Run with STEP1..5 = 3, 7, 11, 15, 19 and tick held 1.
1. rst, then 4-step with no write: quarter_frame pulses after the ticks at cnt = 3, 7, 11, 15; half_frame at 7 and 15; irq=1 one clk after the cnt=15 tick; cnt wraps and quarter_frame repeats at 3.
2. After irq=1, pulse irq_ack: irq=0 on the next cycle. Repeat with irq_ack coincident with the cnt=15 tick: irq remains 1.
3. Write 8'h80: quarter_frame=half_frame=1 one clk later. Next tick sets cnt=0 with no event. Then quarter_frame at 3, 7, 11, 19; half_frame at 7 and 19; no pulse at 15 (step=4); irq never set over two full frames.
4. Write 8'h40 while irq=1: irq=0 next cycle. Run three 4-step frames: irq stays 0 while quarter/half pulses continue normally.
5. Write 8'h00 coincident with the tick at cnt=7: no half_frame from that tick; the following tick resets cnt to 0; the next quarter_frame arrives 4 ticks later.
6. Assert rst asynchronously (mid-clk) during a pending mode-1 strobe: outputs go to 0 immediately and no strobe appears after release.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// APU frame counter ($4017): derives quarter/half-frame strobes and the frame IRQ
// from the APU-cycle tick, in 4-step or 5-step sequence mode.
module apu_frame_sequencer #(
  parameter int unsigned STEP1 = 3728,
  parameter int unsigned STEP2 = 7456,
  parameter int unsigned STEP3 = 11185,
  parameter int unsigned STEP4 = 14914,
  parameter int unsigned STEP5 = 18640,
  parameter int unsigned CNT_W = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       irq,
  output logic       mode,
  output logic [2:0] step
);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);
  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             inhibit_q;
  logic             pending_q;
  logic             hit1, hit2, hit3, hit4, hit5;

  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[5:0];

  always_comb begin
    hit1 = (cnt_q == S1);
    hit2 = (cnt_q == S2);
    hit3 = (cnt_q == S3);
    hit4 = (cnt_q == S4);
    hit5 = mode && (cnt_q == S5);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      mode          <= 1'b0;
      inhibit_q     <= 1'b0;
      irq           <= 1'b0;
      pending_q     <= 1'b0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      step          <= 3'd0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      // Ack is applied first so a same-cycle IRQ set below overrides it.
      if (irq_ack) irq <= 1'b0;

      if (wr_en) begin
        // A tick coinciding with the write is dropped entirely.
        mode      <= wr_data[7];
        inhibit_q <= wr_data[6];
        pending_q <= 1'b1;
        if (wr_data[6]) irq <= 1'b0;
        if (wr_data[7]) begin
          quarter_frame <= 1'b1;
          half_frame    <= 1'b1;
        end
      end else if (tick) begin
        if (pending_q) begin
          cnt_q     <= '0;
          pending_q <= 1'b0;
          step      <= 3'd0;
        end else if (hit1) begin
          quarter_frame <= 1'b1;
          step          <= 3'd1;
          cnt_q         <= cnt_q + One;
        end else if (hit2) begin
          quarter_frame <= 1'b1;
          half_frame    <= 1'b1;
          step          <= 3'd2;
          cnt_q         <= cnt_q + One;
        end else if (hit3) begin
          quarter_frame <= 1'b1;
          step          <= 3'd3;
          cnt_q         <= cnt_q + One;
        end else if (hit4) begin
          if (mode) begin
            step  <= 3'd4;
            cnt_q <= cnt_q + One;
          end else begin
            quarter_frame <= 1'b1;
            half_frame    <= 1'b1;
            step          <= 3'd0;
            cnt_q         <= '0;
            if (!inhibit_q) irq <= 1'b1;
          end
        end else if (hit5) begin
          quarter_frame <= 1'b1;
          half_frame    <= 1'b1;
          step          <= 3'd0;
          cnt_q         <= '0;
        end else begin
          cnt_q <= cnt_q + One;
        end
      end
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer with short step thresholds and tick held high.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       irq_ack = 1'b0;
  logic       quarter_frame, half_frame, irq, mode;
  logic [2:0] step;

  apu_frame_sequencer #(
    .STEP1(3), .STEP2(7), .STEP3(11), .STEP4(15), .STEP5(19), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .wr_data(wr_data),
    .irq_ack(irq_ack), .quarter_frame(quarter_frame), .half_frame(half_frame),
    .irq(irq), .mode(mode), .step(step)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] sb[$];
  logic [6:0] exp_v, got_v;

  // Reference model state, advanced once per clock from the driven inputs.
  int m_cnt, m_step;
  bit m_mode, m_inh, m_irq, m_pend, m_qf, m_hf;
  int thr[6] = '{0, 3, 7, 11, 15, 19};

  function automatic void model_reset();
    m_cnt = 0; m_step = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_pend = 0; m_qf = 0; m_hf = 0;
  endfunction

  function automatic logic [6:0] model_clk(bit t, bit we, logic [7:0] wd, bit ack);
    int hit;
    int last;
    m_qf = 0; m_hf = 0;
    if (ack) m_irq = 0;
    if (we) begin
      m_mode = wd[7]; m_inh = wd[6]; m_pend = 1;
      if (wd[6]) m_irq = 0;
      if (wd[7]) begin m_qf = 1; m_hf = 1; end
    end else if (t) begin
      if (m_pend) begin
        m_cnt = 0; m_pend = 0; m_step = 0;
      end else begin
        hit = 0;
        last = m_mode ? 5 : 4;
        for (int i = 1; i <= last; i++) if (m_cnt == thr[i]) hit = i;
        m_cnt = m_cnt + 1;
        case (hit)
          1, 3: begin m_qf = 1; m_step = hit; end
          2: begin m_qf = 1; m_hf = 1; m_step = 2; end
          4: begin
            if (m_mode) m_step = 4;
            else begin
              m_qf = 1; m_hf = 1; m_step = 0; m_cnt = 0;
              if (!m_inh) m_irq = 1;
            end
          end
          5: begin m_qf = 1; m_hf = 1; m_step = 0; m_cnt = 0; end
          default: ;
        endcase
      end
    end
    return {m_qf, m_hf, m_irq, m_mode, 3'(m_step)};
  endfunction

  function automatic logic [6:0] obs();
    return {quarter_frame, half_frame, irq, mode, step};
  endfunction

  task automatic drive(input bit we, input logic [7:0] wd, input bit ack);
    wr_en = we; wr_data = wd; irq_ack = ack;
    sb.push_back(model_clk(tick, we, wd, ack));
    @(posedge clk); #1;
    wr_en = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== 7'b0) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", obs(), 7'b0);
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_four_step();
    int nq = 0, nh = 0, first_irq = 0;
    for (int n = 1; n <= 20; n++) begin
      drive(0, 8'h00, 0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL four_step cyc %0d: got %b want %b", n, got_v, exp_v);
      end
      if (quarter_frame) nq++;
      if (half_frame) nh++;
      if (irq && first_irq == 0) first_irq = n;
    end
    n_checks++;
    if (nq != 5 || nh != 2) begin
      n_fail++; $display("FAIL four_step_pulses: got q=%0d h=%0d want q=5 h=2", nq, nh);
    end
    n_checks++;
    if (first_irq != 16) begin
      n_fail++; $display("FAIL four_step_irq_cycle: got %0d want 16", first_irq);
    end
  endtask

  task automatic test_irq_ack();
    int guard = 0;
    drive(0, 8'h00, 1);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_ack_clear: got %b want %b", got_v, exp_v);
    end
    while (!(m_cnt == 15 && !m_pend) && guard < 40) begin
      drive(0, 8'h00, 0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL irq_ack_run: got %b want %b", got_v, exp_v);
      end
      guard++;
    end
    n_checks++;
    if (guard >= 40) begin
      n_fail++; $display("FAIL irq_ack_reach15: timed out after %0d cycles", guard);
    end
    drive(0, 8'h00, 1);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || irq !== 1'b1 || half_frame !== 1'b1) begin
      n_fail++; $display("FAIL irq_set_wins: got %b want irq=1 (%b)", got_v, exp_v);
    end
    drive(0, 8'h00, 1);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_ack_second: got %b want %b", got_v, exp_v);
    end
  endtask

  task automatic test_five_step();
    int nq = 0, nh = 0, irq_seen = 0, step4_quiet = 0;
    drive(1, 8'h80, 0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || {quarter_frame, half_frame, mode} !== 3'b111) begin
      n_fail++; $display("FAIL mode1_strobe: got %b want %b", got_v, exp_v);
    end
    drive(0, 8'h00, 0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || quarter_frame !== 1'b0 || step !== 3'd0) begin
      n_fail++; $display("FAIL mode1_pending_tick: got %b want %b", got_v, exp_v);
    end
    for (int n = 1; n <= 40; n++) begin
      drive(0, 8'h00, 0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL five_step cyc %0d: got %b want %b", n, got_v, exp_v);
      end
      if (quarter_frame) nq++;
      if (half_frame) nh++;
      if (irq) irq_seen++;
      if (step == 3'd4 && !quarter_frame && !half_frame) step4_quiet++;
    end
    n_checks++;
    if (nq != 8 || nh != 4 || irq_seen != 0) begin
      n_fail++; $display("FAIL five_step_totals: got q=%0d h=%0d irq=%0d want 8 4 0",
                         nq, nh, irq_seen);
    end
    n_checks++;
    if (step4_quiet == 0) begin
      n_fail++; $display("FAIL five_step_step4: got %0d quiet step-4 cycles want >0", step4_quiet);
    end
  endtask

  task automatic test_inhibit();
    int guard = 0, nq = 0, nh = 0, irq_seen = 0;
    drive(1, 8'h00, 0);
    void'(sb.pop_front());
    while (!irq && guard < 25) begin
      drive(0, 8'h00, 0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL inhibit_setup: got %b want %b", got_v, exp_v);
      end
      guard++;
    end
    n_checks++;
    if (guard != 17) begin
      n_fail++; $display("FAIL inhibit_irq_latency: got %0d cycles want 17", guard);
    end
    drive(1, 8'h40, 0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || irq !== 1'b0) begin
      n_fail++; $display("FAIL inhibit_clear: got %b want %b", got_v, exp_v);
    end
    for (int n = 1; n <= 49; n++) begin
      drive(0, 8'h00, 0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL inhibit_run cyc %0d: got %b want %b", n, got_v, exp_v);
      end
      if (quarter_frame) nq++;
      if (half_frame) nh++;
      if (irq) irq_seen++;
    end
    n_checks++;
    if (nq != 12 || nh != 6 || irq_seen != 0) begin
      n_fail++; $display("FAIL inhibit_totals: got q=%0d h=%0d irq=%0d want 12 6 0",
                         nq, nh, irq_seen);
    end
  endtask

  task automatic test_write_on_step();
    int guard = 0, wait_q = 0;
    while (m_cnt != 7 && guard < 20) begin
      drive(0, 8'h00, 0);
      void'(sb.pop_front());
      guard++;
    end
    drive(1, 8'h00, 0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || half_frame !== 1'b0 || quarter_frame !== 1'b0) begin
      n_fail++; $display("FAIL write_drops_tick: got %b want %b", got_v, exp_v);
    end
    drive(0, 8'h00, 0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v || step !== 3'd0) begin
      n_fail++; $display("FAIL write_pending_reset: got %b want %b", got_v, exp_v);
    end
    while (!quarter_frame && wait_q < 10) begin
      drive(0, 8'h00, 0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL write_restart: got %b want %b", got_v, exp_v);
      end
      wait_q++;
    end
    n_checks++;
    if (wait_q != 4) begin
      n_fail++; $display("FAIL write_restart_gap: got %0d ticks want 4", wait_q);
    end
  endtask

  task automatic test_async_reset();
    int nq = 0;
    drive(1, 8'h80, 0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL async_pre: got %b want %b", got_v, exp_v);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 7'b0) begin
      n_fail++; $display("FAIL async_reset_now: got %b want %b", obs(), 7'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int n = 1; n <= 3; n++) begin
      drive(0, 8'h00, 0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL async_after cyc %0d: got %b want %b", n, got_v, exp_v);
      end
      if (quarter_frame || half_frame) nq++;
    end
    n_checks++;
    if (nq != 0) begin
      n_fail++; $display("FAIL async_no_strobe: got %0d strobes want 0", nq);
    end
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_irq_ack();
    test_five_step();
    test_inhibit();
    test_write_on_step();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
